// File: rtl/mem8_pkg.sv
// Shared definitions for the mem8 arbiter: FSM state encoding and starvation defaults.
package mem8_pkg;

    localparam int STARVE_LIMIT_DEF = 8;
    localparam int CNT_W            = 8;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FREEZE = 1'b1
    } state_e;

endpackage

// File: rtl/mem8_ram.sv
// Single-port 2**ADDR_W x 8 RAM: read-first, registered read data, no reset.
module mem8_ram #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] rdata_q;

    // NOTE: the array and its read register carry no reset; RAM macros have none and contents are undefined after power-up.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem8_arbiter.sv
// Arbitrates a host stream port and a local requester onto one shared RAM, with a
// one-cycle FREEZE that forces the local requester in after sustained starvation.
module mem8_arbiter
    import mem8_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              a_rden,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    output logic              a_empty,
    output logic              a_full,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [7:0]        b_rdata
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             freeze_q;
    logic             a_last_q, a_last_d;
    logic             b_last_q, b_last_d;
    logic [7:0]       a_hold_q, b_hold_q;
    logic [7:0]       ram_rdata;
    logic             host_act, host_gnt;
    logic             ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]       ram_wdata;

    assign host_act = a_rden | a_wren;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        b_gnt    = 1'b0;
        host_gnt = 1'b0;
        case (state_q)
            ST_RUN: begin
                host_gnt = host_act;
                b_gnt    = b_req & ~host_act;
                if (b_req && !b_gnt && cnt_q == LIMIT_M1) begin
                    state_d = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                b_gnt   = b_req;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (b_req && !b_gnt) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Only the granted port reaches the RAM, so two writers can never collide.
    assign ram_en    = host_gnt | b_gnt;
    assign ram_we    = host_gnt ? a_wren  : (b_gnt & b_we);
    assign ram_addr  = host_gnt ? a_addr  : b_addr;
    assign ram_wdata = host_gnt ? a_wdata : b_wdata;
    assign a_last_d  = host_gnt & a_rden;
    assign b_last_d  = b_gnt & ~b_we;

    mem8_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (bus_clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // The shared RAM read register serves both ports; each port shows it only right
    // after its own read and otherwise replays its last captured value.
    assign a_rdata  = a_last_q ? ram_rdata : a_hold_q;
    assign b_rdata  = b_last_q ? ram_rdata : b_hold_q;
    assign b_rvalid = b_last_q;
    assign a_empty  = freeze_q;
    assign a_full   = freeze_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            freeze_q <= 1'b0;
            a_last_q <= 1'b0;
            b_last_q <= 1'b0;
            a_hold_q <= 8'h00;
            b_hold_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            freeze_q <= (state_d == ST_FREEZE);
            a_last_q <= a_last_d;
            b_last_q <= b_last_d;
            a_hold_q <= a_rdata;
            b_hold_q <= b_rdata;
        end
    end

endmodule

// File: tb/tb_mem8_arbiter.sv
// Self-checking bench for mem8_arbiter: cycle-level reference model plus directed scenarios.
module tb_mem8_arbiter;

    localparam int ADDR_W = 5;
    localparam int SL     = 8;

    logic              bus_clk   = 1'b0;
    logic              bus_rst_n = 1'b0;
    logic              a_rden    = 1'b0;
    logic              a_wren    = 1'b0;
    logic [ADDR_W-1:0] a_addr    = '0;
    logic [7:0]        a_wdata   = 8'h00;
    logic [7:0]        a_rdata;
    logic              a_empty;
    logic              a_full;
    logic              b_req     = 1'b0;
    logic              b_we      = 1'b0;
    logic [ADDR_W-1:0] b_addr    = '0;
    logic [7:0]        b_wdata   = 8'h00;
    logic              b_gnt;
    logic              b_rvalid;
    logic [7:0]        b_rdata;

    mem8_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(SL)) dut (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .a_rden    (a_rden),
        .a_wren    (a_wren),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .a_empty   (a_empty),
        .a_full    (a_full),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata)
    );

    always #5 bus_clk = ~bus_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: RAM image, last read values, and a count of consecutive denied cycles.
    logic [7:0] m_mem [2**ADDR_W];
    logic       m_freeze   = 1'b0;
    int         m_denied   = 0;
    logic [7:0] m_a_rdata  = 8'h00;
    logic [7:0] m_b_rdata  = 8'h00;
    logic       m_b_rvalid = 1'b0;
    logic       exp_gnt;
    int         m_dn;

    assign exp_gnt = m_freeze ? b_req : (b_req & ~(a_rden | a_wren));
    assign m_dn    = (b_req && !exp_gnt) ? m_denied + 1 : 0;

    always @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            m_freeze   <= 1'b0;
            m_denied   <= 0;
            m_a_rdata  <= 8'h00;
            m_b_rdata  <= 8'h00;
            m_b_rvalid <= 1'b0;
        end else begin
            if (!m_freeze && a_rden) m_a_rdata <= m_mem[a_addr];
            if (!m_freeze && a_wren) m_mem[a_addr] <= a_wdata;
            if (exp_gnt && b_we)     m_mem[b_addr] <= b_wdata;
            if (exp_gnt && !b_we)    m_b_rdata <= m_mem[b_addr];
            m_b_rvalid <= exp_gnt && !b_we;
            m_denied   <= m_dn;
            m_freeze   <= !m_freeze && (m_dn == SL);
        end
    end

    always @(negedge bus_clk) begin
        check("b_gnt",    8'(b_gnt),    8'(exp_gnt));
        check("a_empty",  8'(a_empty),  8'(m_freeze));
        check("a_full",   8'(a_full),   8'(m_freeze));
        check("b_rvalid", 8'(b_rvalid), 8'(m_b_rvalid));
        if (!$isunknown(m_a_rdata)) check("a_rdata", a_rdata, m_a_rdata);
        if (!$isunknown(m_b_rdata)) check("b_rdata", b_rdata, m_b_rdata);
    end

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic idle();
        a_rden = 1'b0;
        a_wren = 1'b0;
        b_req  = 1'b0;
        b_we   = 1'b0;
    endtask

    task automatic wait_freeze(input string nm);
        int k;
        k = 0;
        while (!a_empty && k < 20) begin
            step();
            k++;
        end
        check(nm, 8'(a_empty), 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int first;
        int last;
        int nfrz;

        repeat (2) step();
        check("rst_a_rdata",  a_rdata,       8'h00);
        check("rst_b_rdata",  b_rdata,       8'h00);
        check("rst_a_empty",  8'(a_empty),   8'd0);
        check("rst_b_rvalid", 8'(b_rvalid),  8'd0);
        bus_rst_n = 1'b1;

        // Host write then read of addr 3, with B contending and losing.
        a_wren = 1'b1; a_addr = 5'd3; a_wdata = 8'hA5;
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd5; b_wdata = 8'h77;
        #1 check("host_wins_wr", 8'(b_gnt), 8'd0);
        step();
        a_wren = 1'b0; a_rden = 1'b1;
        #1 check("host_wins_rd", 8'(b_gnt), 8'd0);
        step();
        idle();
        check("host_read_a5", a_rdata, 8'hA5);

        // B write then read of addr 31 with the host idle.
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd31; b_wdata = 8'h3C;
        #1 check("b_gnt_wr", 8'(b_gnt), 8'd1);
        step();
        b_we = 1'b0;
        #1 check("b_gnt_rd", 8'(b_gnt), 8'd1);
        step();
        idle();
        check("b_rvalid_pulse", 8'(b_rvalid), 8'd1);
        check("b_read_3c",      b_rdata,      8'h3C);
        step();
        check("b_rvalid_drop", 8'(b_rvalid), 8'd0);
        check("b_rdata_hold",  b_rdata,      8'h3C);

        // Same-cycle read and write at addr 7 returns the old data.
        a_wren = 1'b1; a_addr = 5'd7; a_wdata = 8'h11;
        step();
        a_rden = 1'b1; a_wdata = 8'h22;
        step();
        a_wren = 1'b0;
        check("read_first_old", a_rdata, 8'h11);
        step();
        idle();
        check("read_after_new", a_rdata, 8'h22);

        // Host reads continuously while B waits: one FREEZE every 9 cycles.
        a_rden = 1'b1; a_addr = 5'd3;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd31;
        first = -1; last = -1; nfrz = 0;
        for (int i = 1; i <= 27; i++) begin
            step();
            if (a_empty) begin
                nfrz++;
                #1 check("freeze_b_gnt", 8'(b_gnt), 8'd1);
                if (first < 0) first = i;
                else check("freeze_period", 8'(i - last), 8'd9);
                last = i;
            end
        end
        check("first_freeze", 8'(first), 8'd8);
        check("freeze_count", 8'(nfrz),  8'd3);

        // Host write attempted during FREEZE must be dropped.
        wait_freeze("freeze_seen_1");
        a_wren = 1'b1; a_wdata = 8'hEE;
        step();
        a_wren = 1'b0;
        check("freeze_rdata_hold", a_rdata, 8'hA5);
        step();
        check("freeze_no_write", a_rdata, 8'hA5);

        // Reset during FREEZE drops the flags without a clock edge.
        wait_freeze("freeze_seen_2");
        #2 bus_rst_n = 1'b0;
        #1 check("async_a_empty", 8'(a_empty), 8'd0);
        check("async_a_full", 8'(a_full), 8'd0);
        idle();
        step();
        bus_rst_n = 1'b1;
        check("post_rst_a_rdata", a_rdata, 8'h00);
        a_rden = 1'b1; a_addr = 5'd3;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd31;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a_empty && first < 0) first = i;
        end
        check("post_rst_first_freeze", 8'(first), 8'd8);
        idle();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
